// File: rtl/ids_pim_pkg.sv
// ids_pim_pkg: PIM window map, sizing, status/command bit positions and FSM states.
package ids_pim_pkg;
   localparam logic [31:0] PIM_CTRL         = 32'h4000_0010;
   localparam logic [31:0] PIM_R            = 32'h4000_0020;
   localparam logic [31:0] PIM_W_WEIGHT     = 32'h4000_0040;
   localparam logic [31:0] PIM_W_ACTIVATION = 32'h4000_0080;
   localparam int NUM_MACRO = 4;
   localparam int WGT_ROWS  = 64;
   localparam int ACT_WORDS = 8;
   localparam int RES_WORDS = 4;
   localparam int ST_BUSY    = 0;
   localparam int ST_VALID   = 1;
   localparam int ST_ERR     = 2;
   localparam int ST_SEL_LSB = 4;
   localparam int CMD_CLR_ERR = 2;
   localparam int CMD_RST_PTR = 3;
   typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_RESULT} pim_state_e;
endpackage

// File: rtl/ids_pim_result_buf.sv
// ids_pim_result_buf: captures one compute's results and serves them in order, one registered word per read.
module ids_pim_result_buf
   import ids_pim_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cap,
   input  logic [RES_WORDS*32-1:0] i_result,
   input  logic                   i_rd,
   output logic                   o_drain,
   output logic [31:0]            o_rd_data
);
   localparam int PW = $clog2(RES_WORDS);
   logic [RES_WORDS-1:0][31:0] res_q;
   logic [PW-1:0] ptr_q;
   logic [31:0] rd_data_q;
   assign o_drain   = i_rd && ptr_q == PW'(RES_WORDS - 1);
   assign o_rd_data = rd_data_q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         res_q     <= '0;
         ptr_q     <= '0;
         rd_data_q <= '0;
      end else begin
         if (i_cap) res_q <= i_result;
         ptr_q     <= i_cap ? '0 : i_rd ? ptr_q + PW'(1) : ptr_q;
         rd_data_q <= i_rd ? res_q[ptr_q] : '0;
      end
endmodule

// File: rtl/ids_pim_target.sv
// ids_pim_target: decodes DMA single-word accesses into status, weight rows, activation launch and result readout.
module ids_pim_target
   import ids_pim_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [31:0]                 i_addr,
   input  logic                        i_write,
   input  logic                        i_read,
   input  logic [3:0]                  i_size,
   input  logic [31:0]                 i_wr_data,
   output logic [31:0]                 o_rd_data,
   output logic [3:0]                  o_mac_sel,
   output logic                        o_mac_wgt_we,
   output logic [$clog2(WGT_ROWS)-1:0] o_mac_wgt_row,
   output logic [31:0]                 o_mac_wgt_data,
   output logic [ACT_WORDS*32-1:0]     o_mac_act,
   output logic                        o_mac_start,
   input  logic                        i_mac_done,
   input  logic [RES_WORDS*32-1:0]     i_mac_result
);
   localparam int RW = $clog2(WGT_ROWS);
   localparam int CW = $clog2(ACT_WORDS + 1);
   localparam int SW = $clog2(NUM_MACRO);
   pim_state_e state_q, state_d;
   logic [NUM_MACRO-1:0][RW-1:0] ptr_q, ptr_d;
   logic [ACT_WORDS-1:0][31:0] act_q, act_d;
   logic [CW-1:0] act_cnt_q, act_cnt_d;
   logic [3:0] tgt_q, tgt_d, wsel_q, wsel_d;
   logic wgt_we_q, wgt_we_d, err_q, err_d;
   logic [RW-1:0] wgt_row_q, wgt_row_d;
   logic [31:0] wgt_data_q, wgt_data_d, status, rb_data;
   logic [3:0] sel;
   logic hit_c, hit_r, hit_w, hit_a, bad, wr, rd, busy, valid, full;
   logic wgt_ok, act_ok, res_rd, stat_rd, err_set, cap, drain;
   always_comb begin
      sel     = i_addr[3:0];
      hit_c   = i_addr[31:4] == PIM_CTRL[31:4];
      hit_r   = i_addr[31:4] == PIM_R[31:4];
      hit_w   = i_addr[31:4] == PIM_W_WEIGHT[31:4];
      hit_a   = i_addr[31:4] == PIM_W_ACTIVATION[31:4];
      busy    = state_q inside {S_START, S_WAIT};
      valid   = state_q == S_RESULT;
      full    = act_cnt_q == CW'(ACT_WORDS);
      bad     = i_size != 4'hF || !(hit_c || ((hit_r || hit_w || hit_a) && 32'(sel) < NUM_MACRO));
      wr      = i_write && !bad;
      rd      = i_read && !i_write && !bad;
      wgt_ok  = wr && hit_w && !busy;
      act_ok  = wr && hit_a && !busy && !full;
      res_rd  = rd && hit_r && valid;
      stat_rd = rd && hit_c;
      cap     = state_q == S_WAIT && i_mac_done;
      // any access that reaches a window but is not served flags an error
      err_set = ((i_write || i_read) && bad) || (i_write && i_read) ||
                (wr && !hit_c && !wgt_ok && !act_ok) || (rd && !hit_c && !res_rd);
      err_d   = err_set || (err_q && !(wr && hit_c && i_wr_data[CMD_CLR_ERR]));
      for (int i = 0; i < NUM_MACRO; i++)
         ptr_d[i] = (wr && hit_c && i_wr_data[CMD_RST_PTR]) ? '0 :
                    (wgt_ok && sel == 4'(i)) ? ((ptr_q[i] == RW'(WGT_ROWS - 1)) ? '0 : ptr_q[i] + RW'(1)) :
                    ptr_q[i];
      for (int i = 0; i < ACT_WORDS; i++)
         act_d[i] = (act_ok && act_cnt_q == CW'(i)) ? i_wr_data : act_q[i];
      act_cnt_d  = cap ? '0 : act_ok ? act_cnt_q + CW'(1) : act_cnt_q;
      tgt_d      = act_ok ? sel : tgt_q;
      wgt_we_d   = wgt_ok;
      wsel_d     = wgt_ok ? sel : wsel_q;
      wgt_row_d  = wgt_ok ? ptr_q[sel[SW-1:0]] : wgt_row_q;
      wgt_data_d = wgt_ok ? i_wr_data : wgt_data_q;
      status                      = '0;
      status[ST_BUSY]             = busy;
      status[ST_VALID]            = valid;
      status[ST_ERR]              = err_q;
      status[ST_SEL_LSB +: 4]     = tgt_q;
      state_d = state_q;
      case (state_q)
         S_FILL:   state_d = (act_cnt_d == CW'(ACT_WORDS)) ? S_START : S_FILL;
         S_START:  state_d = S_WAIT;
         S_WAIT:   state_d = i_mac_done ? S_RESULT : S_WAIT;
         S_RESULT: state_d = !drain ? S_RESULT : (act_cnt_d == CW'(ACT_WORDS)) ? S_START : S_FILL;
         default:  state_d = S_FILL;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q    <= S_FILL;
         ptr_q      <= '0;
         act_q      <= '0;
         act_cnt_q  <= '0;
         tgt_q      <= '0;
         wsel_q     <= '0;
         wgt_we_q   <= 1'b0;
         wgt_row_q  <= '0;
         wgt_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         act_q      <= act_d;
         act_cnt_q  <= act_cnt_d;
         tgt_q      <= tgt_d;
         wsel_q     <= wsel_d;
         wgt_we_q   <= wgt_we_d;
         wgt_row_q  <= wgt_row_d;
         wgt_data_q <= wgt_data_d;
         err_q      <= err_d;
      end
   ids_pim_result_buf u_rbuf (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_cap     (cap),
      .i_result  (i_mac_result),
      .i_rd      (res_rd),
      .o_drain   (drain),
      .o_rd_data (rb_data)
   );
   assign o_rd_data      = stat_rd ? status : rb_data;
   assign o_mac_sel      = wgt_we_q ? wsel_q : tgt_q;
   assign o_mac_wgt_we   = wgt_we_q;
   assign o_mac_wgt_row  = wgt_row_q;
   assign o_mac_wgt_data = wgt_data_q;
   assign o_mac_act      = act_q;
   assign o_mac_start    = state_q == S_START;
endmodule

// File: tb/tb_ids_pim_target.sv
// tb_ids_pim_target: directed vector table plus hand sequences for reset and reset-during-compute.
module tb_ids_pim_target;
   import ids_pim_pkg::*;
   typedef struct {
      logic        w, r, dn, cn, we, st;
      logic [3:0]  sz, sel;
      logic [31:0] a, d, rd_now, rd_nxt;
      logic [5:0]  row;
   } vec_t;
   localparam logic [31:0] RA = 32'hA0A0_0001, RB = 32'hB0B0_0002, RC = 32'hC0C0_0003, RD = 32'hD0D0_0004;
   logic i_clk = 1'b0, i_rst_n = 1'b0;
   logic [31:0] i_addr = '0, i_wr_data = '0, o_rd_data, o_mac_wgt_data;
   logic i_write = 1'b0, i_read = 1'b0, i_mac_done = 1'b0, o_mac_wgt_we, o_mac_start;
   logic [3:0] i_size = 4'hF, o_mac_sel;
   logic [5:0] o_mac_wgt_row;
   logic [ACT_WORDS*32-1:0] o_mac_act, exp_act;
   logic [RES_WORDS*32-1:0] i_mac_result = {RD, RC, RB, RA};
   vec_t vq[$];
   int n_chk = 0, n_fail = 0;
   always #5 i_clk = ~i_clk;
   ids_pim_target dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_write(i_write), .i_read(i_read),
      .i_size(i_size), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data), .o_mac_sel(o_mac_sel),
      .o_mac_wgt_we(o_mac_wgt_we), .o_mac_wgt_row(o_mac_wgt_row), .o_mac_wgt_data(o_mac_wgt_data),
      .o_mac_act(o_mac_act), .o_mac_start(o_mac_start), .i_mac_done(i_mac_done), .i_mac_result(i_mac_result)
   );
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic idle();
      i_write = 1'b0; i_read = 1'b0; i_mac_done = 1'b0; i_addr = '0; i_wr_data = '0; i_size = 4'hF;
   endtask
   function automatic vec_t blank();
      vec_t v = '{default: '0};
      v.sz = 4'hF;
      return v;
   endfunction
   task automatic stat(input logic [31:0] exp, input logic dn = 1'b0);
      vec_t v = blank();
      v.r = 1'b1; v.a = PIM_CTRL; v.cn = 1'b1; v.rd_now = exp; v.dn = dn;
      vq.push_back(v);
   endtask
   task automatic wgt(input logic [3:0] sel, input logic [31:0] d, input logic [5:0] row);
      vec_t v = blank();
      v.w = 1'b1; v.a = PIM_W_WEIGHT | 32'(sel); v.d = d; v.we = 1'b1; v.sel = sel; v.row = row;
      vq.push_back(v);
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic st = 1'b0, input logic [3:0] sz = 4'hF);
      vec_t v = blank();
      v.w = 1'b1; v.a = a; v.d = d; v.st = st; v.sz = sz;
      vq.push_back(v);
   endtask
   task automatic rres(input logic [31:0] exp, input logic st = 1'b0);
      vec_t v = blank();
      v.r = 1'b1; v.a = PIM_R | 32'h2; v.rd_nxt = exp; v.st = st;
      vq.push_back(v);
   endtask
   task automatic acts(input logic [3:0] sel, input logic [31:0] base, input logic st_last);
      for (int i = 0; i < ACT_WORDS; i++) wr(PIM_W_ACTIVATION | 32'(sel), base + 32'(i), st_last && i == ACT_WORDS - 1);
   endtask
   initial begin
      automatic vec_t vb;
      stat(32'h0);
      for (int i = 0; i < 4; i++) wgt(4'd1, 32'h11 + 32'(i), 6'(i));
      for (int i = 0; i < 66; i++) wgt(4'd0, 32'h200 + 32'(i), 6'(i % 64));
      stat(32'h0);
      wr(PIM_W_WEIGHT | 32'h1, 32'h99, 1'b0, 4'h3);
      wr(PIM_W_WEIGHT | 32'h4, 32'h98);
      stat(32'h04);
      wr(PIM_CTRL, 32'h8);
      stat(32'h04);
      wr(PIM_CTRL, 32'h4);
      wgt(4'd1, 32'h55, 6'd0);
      stat(32'h0);
      vb = blank(); vb.w = 1'b1; vb.r = 1'b1; vb.a = PIM_CTRL; vb.cn = 1'b1; vb.rd_now = 32'h0;
      vq.push_back(vb);
      stat(32'h04);
      wr(PIM_CTRL, 32'h4);
      stat(32'h0);
      acts(4'd2, 32'h100, 1'b1);
      stat(32'h21);
      wr(PIM_W_WEIGHT | 32'h1, 32'h77);
      wr(PIM_W_ACTIVATION | 32'h2, 32'h78);
      stat(32'h25);
      wr(PIM_CTRL, 32'h4);
      stat(32'h21);
      vb = blank(); vb.dn = 1'b1;
      vq.push_back(vb);
      stat(32'h22);
      rres(RA); rres(RB); rres(RC); rres(RD);
      stat(32'h20);
      rres(32'h0);
      stat(32'h24);
      wr(PIM_CTRL, 32'h4);
      acts(4'd2, 32'h300, 1'b1);
      stat(32'h21);
      stat(32'h21, 1'b1);
      acts(4'd3, 32'h400, 1'b0);
      stat(32'h32);
      rres(RA); rres(RB); rres(RC); rres(RD, 1'b1);
      stat(32'h31);
      #12 chk("reset rd_data", o_rd_data, 0);
      chk("reset act", o_mac_act, 0);
      chk("reset start/we/sel", {o_mac_start, o_mac_wgt_we, o_mac_sel}, 0);
      chk("reset row/data", {o_mac_wgt_row, o_mac_wgt_data}, 0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      foreach (vq[k]) begin
         automatic vec_t v = vq[k];
         #1;
         i_write = v.w; i_read = v.r; i_addr = v.a; i_wr_data = v.d; i_size = v.sz; i_mac_done = v.dn;
         #1;
         if (v.cn) chk($sformatf("v%0d status", k), o_rd_data, v.rd_now);
         @(posedge i_clk); #1;
         idle();
         #1;
         chk($sformatf("v%0d rd_data", k), o_rd_data, v.rd_nxt);
         chk($sformatf("v%0d start", k), o_mac_start, v.st);
         chk($sformatf("v%0d wgt_we", k), o_mac_wgt_we, v.we);
         if (v.we) chk($sformatf("v%0d sel/row/data", k), {o_mac_sel, o_mac_wgt_row, o_mac_wgt_data}, {v.sel, v.row, v.d});
      end
      for (int i = 0; i < ACT_WORDS; i++) exp_act[i*32 +: 32] = 32'h400 + 32'(i);
      chk("act vector", o_mac_act, exp_act);
      i_rst_n = 1'b0;
      i_read = 1'b1; i_addr = PIM_CTRL;
      #1;
      chk("mid-wait reset status", o_rd_data, 0);
      chk("mid-wait reset act/start", {o_mac_act, o_mac_start}, 0);
      idle();
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      i_mac_done = 1'b1;
      @(posedge i_clk); #1;
      idle();
      i_read = 1'b1; i_addr = PIM_CTRL;
      #1;
      chk("late done ignored", o_rd_data, 0);
      chk("late done no start", o_mac_start, 0);
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
